pipe_skid_reg: RTL
==================

// Module: pipe_skid_reg
// PURPOSE
//  Registered pipeline stage with a valid/ready handshake and a one-entry skid buffer.
//  It sits directly downstream of the pipeline's 2:1 operand/PC select muxes.
//  It captures the selected N-bit value and forwards it to the next stage.
//  It absorbs one-cycle back-pressure without a combinational ready path upstream.
//  Used between pipeline stages wherever stall (ready low) and flush must be honoured.
// PARAMETERS
//  N      32   data width in bits (mux output width)
// PORTS
//  clk        in   1   clock, all state updates on rising edge
//  rst        in   1   synchronous reset, active-low (0 = reset)
//  flush      in   1   synchronous discard of all held entries
//  in_valid   in   1   upstream presents in_data this cycle
//  in_ready   out  1   stage can accept a word this cycle
//  in_data    in   N   word from select mux
//  out_valid  out  1   out_data holds a valid word
//  out_ready  in   1   downstream consumes out_data this cycle
//  out_data   out  N   oldest held word
// BEHAVIOUR
//  - Single clock. Reset is synchronous and active-low: sampled only at a rising clk edge with rst==0.
//  - Reset state: out_valid=0, out_data=0, skid entry empty/0, state EMPTY.
//  - in_ready=0 combinationally whenever rst==0; otherwise in_ready = ~skid_valid.
//  - in_ready depends on registered state only; it has no path from out_ready.
//  - Transfers:
//    - accept = in_valid & in_ready.
//    - send   = out_valid & out_ready.
//    - Both are evaluated on the same edge.
//  - States:
//    - EMPTY: main invalid.
//    - ONE: main valid, skid empty.
//    - FULL: main and skid valid.
//  - EMPTY: accept -> ONE, main<=in_data. No accept -> stay.
//  - ONE:
//    - accept&send  -> ONE, main<=in_data.
//    - accept&~send -> FULL, skid<=in_data.
//    - ~accept&send -> EMPTY.
//    - else stay.
//  - FULL (in_ready=0): send -> ONE, main<=skid. Otherwise hold.
//  - Latency: a word accepted at edge k is visible on out_data after edge k (out_valid=1 in cycle k+1).
//    That holds when the stage was EMPTY, or ONE with send at the same edge.
//  - Ordering is strict FIFO; no word is duplicated or dropped except by flush/reset.
//  - Stability: while out_valid & ~out_ready, out_data and out_valid hold unchanged.
//  - Flush (rst==1, flush==1):
//    - Next state is EMPTY and out_valid=0.
//    - Any accept in that cycle is discarded.
//    - A send in that cycle still counts for downstream.
//  - Priority: reset > flush > normal transfer.
//  - Reset mid-operation: all held words are lost; out_data returns to 0.
//  - Data registers may keep stale values when invalid, except out_data after reset.
//  - No arithmetic; data passes bit-exact, width N on all data paths.
// TESTING
//  1. rst=0 for 2 cycles -> out_valid=0, out_data=0, in_ready=0.
//     Release rst -> in_ready=1 next cycle.
//  2. in_valid=1, data 0x11,0x22,0x33 on consecutive cycles, out_ready=1 ->
//     out_data 0x11,0x22,0x33 one cycle later each, in_ready stays 1.
//  3. out_ready=0, push 0xA then 0xB ->
//     FULL, in_ready=0, out_data=0xA held.
//     out_ready=1 -> 0xA then 0xB delivered, in_ready=1 after first send.
//  4. FULL (0xA,0xB) plus flush=1 with in_valid=1, data 0xC ->
//     next cycle out_valid=0, in_ready=1, 0xC never appears.
//  5. ONE holding 0x5, out_ready=0, rst=0 for one cycle ->
//     out_valid=0, out_data=0, 0x5 never delivered.
//  6. Random in_valid/out_ready for 10k cycles, N=32 ->
//     output sequence equals input sequence, no loss or duplication.
//     Scoreboard plus assertion that out_data is stable under stall.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - registered valid/ready pipeline stage with one-entry skid buffer
module pipe_skid_reg #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t       state;
    logic         skid_valid;
    logic [N-1:0] skid_data;
    logic         accept;
    logic         send;

    // Ready comes from registered occupancy only, so upstream never sees out_ready combinationally.
    assign in_ready = rst & ~skid_valid;
    assign accept   = in_valid & in_ready;
    assign send     = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= EMPTY;
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (flush) begin
            state      <= EMPTY;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state     <= ONE;
                        out_valid <= 1'b1;
                        out_data  <= in_data;
                    end
                end
                ONE: begin
                    if (accept && send) begin
                        out_data <= in_data;
                    end else if (accept) begin
                        state      <= FULL;
                        skid_valid <= 1'b1;
                        skid_data  <= in_data;
                    end else if (send) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                FULL: begin
                    // Skid word moves up behind the departing head to keep FIFO order.
                    if (send) begin
                        state      <= ONE;
                        out_data   <= skid_data;
                        skid_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    out_valid  <= 1'b0;
                    skid_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
